clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
Sequencing and time-set controller for the seconds/minutes/hours counter chain of the digital clock. In RUN it generates the per-counter count enables from the 1 Hz tick and the counters' RCO outputs. In the SET states it freezes counting, holds an edit value adjusted by inc/dec buttons, and drives the shared load/mode/value bus that the counters load from. It sits between the debounced button logic and the three counter instances.

Parameters:
SEC_MAX, 60, seconds modulus
MIN_MAX, 60, minutes modulus
HR_MAX, 24, hours modulus
TIMEOUT_S, 30, 1 Hz ticks without a button press before a SET state auto-returns to RUN

Ports:
Clk  input  1  system clock, all state updated on posedge
Clr  input  1  reset, asynchronous, active-high
tick_1hz  input  1  one-Clk-wide pulse once per second
btn_mode  input  1  debounced single-cycle pulse: advance mode
btn_inc  input  1  debounced single-cycle pulse: increment edit value
btn_dec  input  1  debounced single-cycle pulse: decrement edit value
sec_rco  input  1  seconds counter ripple carry
min_rco  input  1  minutes counter ripple carry
hr_q  input  6  current hours count
min_q  input  6  current minutes count
sec_en  output  1  seconds counter Enable
min_en  output  1  minutes counter Enable
hr_en  output  1  hours counter Enable
load  output  1  shared counter load strobe
mode  output  2  shared counter mode select
value  output  6  shared counter load value

Behaviour:
- Reset (Clr=1, asynchronous): state=RUN, value=0, timeout count=0. All outputs are 0: load=0, mode=0, and all enables 0.
- State encoding equals the mode output: RUN=0, SET_HR=1, SET_MIN=2, SET_SEC=3. mode is registered and equals the state.
- RUN, combinational enables:
  - sec_en = tick_1hz
  - min_en = tick_1hz & sec_rco
  - hr_en = tick_1hz & sec_rco & min_rco
  - load = 0
- SET states: sec_en = min_en = hr_en = 0; load = 1 continuously. The counter whose mode matches loads value every cycle.
- btn_mode transitions, taking effect on the same edge:
  - RUN -> SET_HR, with value <= hr_q
  - SET_HR -> SET_MIN, with value <= min_q
  - SET_MIN -> SET_SEC, with value <= 0
  - SET_SEC -> RUN
- Because value is captured on entry, the first cycle with load=1 rewrites the counter's unchanged count.
- Edit arithmetic in SET_HR/SET_MIN. Modulus M = HR_MAX or MIN_MAX.
  - inc: value = (value+1 == M) ? 0 : value+1
  - dec: value = (value == 0) ? M-1 : value-1
  - Result is visible on the next cycle and loaded by the counter on the following edge.
- SET_SEC: value stays 0 and inc/dec are ignored, so seconds are zeroed.
- Simultaneous events:
  - btn_mode wins over inc/dec in the same cycle; inc/dec are discarded.
  - inc and dec together produce no change.
  - tick_1hz in a SET state does not count time.
- Timeout:
  - Counter clears on state entry and on any btn_inc/btn_dec/btn_mode.
  - Counter increments on tick_1hz in SET states.
  - When it reaches TIMEOUT_S, state -> RUN on that edge. The already-loaded value is kept (implicit commit).
  - Counter width is clog2(TIMEOUT_S+1) and it saturates; it never wraps.
- Reset mid-edit returns to RUN immediately. The counters' own reset state is not this block's concern.
- Buttons in RUN other than btn_mode are ignored.

Decomposition:
- Shared package clock_pkg holds:
  - typedef enum logic [1:0] mode_t {MODE_RUN, MODE_HR, MODE_MIN, MODE_SEC}
  - constants SEC_MAX/MIN_MAX/HR_MAX
  - typedef logic [5:0] time_val_t
- One natural sub-module, mod_updown, is the wrap-around inc/dec arithmetic parameterised by modulus. It is reused for the hours and minutes edit paths.
- The FSM and the timeout counter stay in the top block.

Test Plan:
- Reset: assert Clr mid-cycle -> outputs 0 and mode=0 asynchronously, with no clock edge required.
- Run chaining: sec_rco=1, min_rco=1, tick_1hz pulse -> sec_en, min_en and hr_en all 1 for exactly that cycle; with min_rco=0 -> hr_en=0.
- Hour edit with wrap: hr_q=23, btn_mode -> mode=1, value=23, load=1. btn_inc -> value=0. btn_dec -> value=23. Further btn_dec -> 22.
- Minute edit with wrap: btn_mode from SET_HR with min_q=0 -> mode=2, value=0. btn_dec -> value=59. btn_inc and btn_dec in the same cycle -> value stays 59.
- Full cycle and precedence: btn_mode and btn_inc together in SET_MIN -> SET_SEC, value=0, inc ignored. btn_mode -> RUN with load=0. All enables are 0 throughout the SET states even with tick pulses.
- Timeout: enter SET_HR, apply 30 ticks with no buttons -> returns to RUN on the 30th tick. A btn_inc at tick 29 restarts the count, so return happens 30 ticks later.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and moduli for the digital clock counter chain and its set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN = 2'd0,
    MODE_HR  = 2'd1,
    MODE_MIN = 2'd2,
    MODE_SEC = 2'd3
  } mode_t;

  localparam int SEC_MAX = 60;
  localparam int MIN_MAX = 60;
  localparam int HR_MAX  = 24;

  typedef logic [5:0] time_val_t;

endpackage

// File: rtl/mod_updown.sv
// Wrap-around increment/decrement of a value modulo M; purely combinational.
// inc and dec together, or neither, pass the value through unchanged.
module mod_updown #(
  parameter int M = 60,
  parameter int W = 6
) (
  input  logic [W-1:0] i_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_val
);

  logic [W-1:0] w_plus;
  logic [W-1:0] w_minus;

  assign w_plus  = i_val + 1'b1;
  assign w_minus = i_val - 1'b1;

  always_comb begin
    o_val = i_val;
    if (i_inc && !i_dec) begin
      o_val = (w_plus == W'(M)) ? '0 : w_plus;
    end else if (i_dec && !i_inc) begin
      o_val = (i_val == '0) ? W'(M - 1) : w_minus;
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Run/set sequencer for the sec/min/hr counter chain: count enables in RUN,
// edit value plus shared load bus in the SET states, auto-return on inactivity.
module clock_set_controller #(
  parameter int SEC_MAX   = clock_pkg::SEC_MAX,
  parameter int MIN_MAX   = clock_pkg::MIN_MAX,
  parameter int HR_MAX    = clock_pkg::HR_MAX,
  parameter int TIMEOUT_S = 30
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       sec_rco,
  input  logic       min_rco,
  input  logic [5:0] hr_q,
  input  logic [5:0] min_q,
  output logic       sec_en,
  output logic       min_en,
  output logic       hr_en,
  output logic       load,
  output logic [1:0] mode,
  output logic [5:0] value
);

  import clock_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT_S + 1);

  // The edit value is 6 bits wide, so every modulus must fit in it.
  if (SEC_MAX > 64 || MIN_MAX > 64 || HR_MAX > 64) begin : g_modulus_range
    $error("clock_set_controller: modulus does not fit a 6-bit value");
  end

  mode_t            r_state;
  mode_t            w_state_nxt;
  time_val_t        r_value;
  time_val_t        w_value_nxt;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic [TMO_W-1:0] w_tmo_tick;
  time_val_t        w_hr_upd;
  time_val_t        w_min_upd;
  logic             w_edit;

  mod_updown #(.M(HR_MAX), .W(6)) u_hr_updown (
    .i_val (r_value),
    .i_inc (btn_inc),
    .i_dec (btn_dec),
    .o_val (w_hr_upd)
  );

  mod_updown #(.M(MIN_MAX), .W(6)) u_min_updown (
    .i_val (r_value),
    .i_inc (btn_inc),
    .i_dec (btn_dec),
    .o_val (w_min_upd)
  );

  assign w_edit     = btn_inc | btn_dec;
  assign w_tmo_tick = (r_tmo == TMO_W'(TIMEOUT_S)) ? r_tmo : r_tmo + 1'b1;

  // Priority inside a SET state: mode button, then inc/dec, then tick.
  always_comb begin
    w_state_nxt = r_state;
    w_value_nxt = r_value;
    w_tmo_nxt   = r_tmo;
    unique case (r_state)
      MODE_RUN: begin
        w_tmo_nxt = '0;
        if (btn_mode) begin
          w_state_nxt = MODE_HR;
          w_value_nxt = hr_q;
        end
      end
      MODE_HR: begin
        if (btn_mode) begin
          w_state_nxt = MODE_MIN;
          w_value_nxt = min_q;
          w_tmo_nxt   = '0;
        end else if (w_edit) begin
          w_value_nxt = w_hr_upd;
          w_tmo_nxt   = '0;
        end else if (tick_1hz) begin
          w_tmo_nxt   = w_tmo_tick;
        end
      end
      MODE_MIN: begin
        if (btn_mode) begin
          w_state_nxt = MODE_SEC;
          w_value_nxt = '0;
          w_tmo_nxt   = '0;
        end else if (w_edit) begin
          w_value_nxt = w_min_upd;
          w_tmo_nxt   = '0;
        end else if (tick_1hz) begin
          w_tmo_nxt   = w_tmo_tick;
        end
      end
      MODE_SEC: begin
        w_value_nxt = '0;
        if (btn_mode) begin
          w_state_nxt = MODE_RUN;
          w_tmo_nxt   = '0;
        end else if (w_edit) begin
          w_tmo_nxt   = '0;
        end else if (tick_1hz) begin
          w_tmo_nxt   = w_tmo_tick;
        end
      end
    endcase
    if (r_state != MODE_RUN && w_tmo_nxt == TMO_W'(TIMEOUT_S)) begin
      w_state_nxt = MODE_RUN;
      w_tmo_nxt   = '0;
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state <= MODE_RUN;
      r_value <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_value <= w_value_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  always_comb begin
    sec_en = 1'b0;
    min_en = 1'b0;
    hr_en  = 1'b0;
    load   = 1'b1;
    if (r_state == MODE_RUN) begin
      sec_en = tick_1hz;
      min_en = tick_1hz & sec_rco;
      hr_en  = tick_1hz & sec_rco & min_rco;
      load   = 1'b0;
    end
  end

  assign mode  = r_state;
  assign value = r_value;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed self-checking bench for clock_set_controller.
module tb_clock_set_controller;

  logic       Clk;
  logic       Clr;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic       sec_rco;
  logic       min_rco;
  logic [5:0] hr_q;
  logic [5:0] min_q;
  logic       sec_en;
  logic       min_en;
  logic       hr_en;
  logic       load;
  logic [1:0] mode;
  logic [5:0] value;

  int n_tests = 0;
  int n_fail  = 0;

  clock_set_controller #(
    .SEC_MAX   (60),
    .MIN_MAX   (60),
    .HR_MAX    (24),
    .TIMEOUT_S (30)
  ) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .tick_1hz (tick_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .sec_rco  (sec_rco),
    .min_rco  (min_rco),
    .hr_q     (hr_q),
    .min_q    (min_q),
    .sec_en   (sec_en),
    .min_en   (min_en),
    .hr_en    (hr_en),
    .load     (load),
    .mode     (mode),
    .value    (value)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold the given inputs across exactly one rising edge, then release them.
  task automatic pulse(input logic m, input logic i, input logic d, input logic t);
    btn_mode = m;
    btn_inc  = i;
    btn_dec  = d;
    tick_1hz = t;
    @(posedge Clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    tick_1hz = 1'b0;
    #1;
  endtask

  initial begin
    Clr = 1'b1;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    sec_rco  = 1'b0;
    min_rco  = 1'b0;
    hr_q     = 6'd0;
    min_q    = 6'd0;
    repeat (3) @(posedge Clk);
    #1;
    Clr = 1'b0;
    #1;
    check("reset_mode", 8'(mode), 8'd0);
    check("reset_load", 8'(load), 8'd0);
    check("reset_value", 8'(value), 8'd0);
    check("reset_enables", 8'({sec_en, min_en, hr_en}), 8'd0);

    // RUN chaining
    sec_rco = 1'b1;
    min_rco = 1'b1;
    tick_1hz = 1'b1;
    #1;
    check("run_chain_all", 8'({sec_en, min_en, hr_en}), 8'b111);
    min_rco = 1'b0;
    #1;
    check("run_chain_no_hr", 8'({sec_en, min_en, hr_en}), 8'b110);
    @(posedge Clk);
    #1;
    tick_1hz = 1'b0;
    #1;
    check("run_no_tick", 8'({sec_en, min_en, hr_en}), 8'b000);
    check("run_mode_after_tick", 8'(mode), 8'd0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("run_inc_ignored", 8'(value), 8'd0);

    // Hour edit with wrap
    min_rco = 1'b1;
    hr_q = 6'd23;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("hr_enter_mode", 8'(mode), 8'd1);
    check("hr_enter_value", 8'(value), 8'd23);
    check("hr_enter_load", 8'(load), 8'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("hr_inc_wrap", 8'(value), 8'd0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("hr_dec_wrap", 8'(value), 8'd23);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("hr_dec", 8'(value), 8'd22);
    tick_1hz = 1'b1;
    #1;
    check("hr_tick_enables", 8'({sec_en, min_en, hr_en}), 8'b000);
    @(posedge Clk);
    #1;
    tick_1hz = 1'b0;
    check("hr_tick_value", 8'(value), 8'd22);

    // Minute edit with wrap
    min_q = 6'd0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("min_enter_mode", 8'(mode), 8'd2);
    check("min_enter_value", 8'(value), 8'd0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("min_dec_wrap", 8'(value), 8'd59);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("min_inc_dec_same", 8'(value), 8'd59);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("min_inc_wrap", 8'(value), 8'd0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("min_dec_again", 8'(value), 8'd59);

    // Precedence and SET_SEC
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("sec_enter_mode", 8'(mode), 8'd3);
    check("sec_enter_value", 8'(value), 8'd0);
    tick_1hz = 1'b1;
    #1;
    check("sec_tick_enables", 8'({sec_en, min_en, hr_en, load}), 8'b0001);
    @(posedge Clk);
    #1;
    tick_1hz = 1'b0;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("sec_inc_ignored", 8'(value), 8'd0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("back_run_mode", 8'(mode), 8'd0);
    check("back_run_load", 8'(load), 8'd0);

    // Asynchronous reset mid-edit
    hr_q = 6'd7;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_clr_value", 8'(value), 8'd7);
    #1;
    Clr = 1'b1;
    #1;
    check("async_clr_mode", 8'(mode), 8'd0);
    check("async_clr_load", 8'(load), 8'd0);
    check("async_clr_value", 8'(value), 8'd0);
    @(posedge Clk);
    #1;
    Clr = 1'b0;
    #1;

    // Timeout without buttons
    hr_q = 6'd5;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("tmo_enter", 8'(mode), 8'd1);
    for (int k = 0; k < 29; k++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("tmo_29_still_set", 8'(mode), 8'd1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("tmo_30_run", 8'(mode), 8'd0);
    check("tmo_30_load", 8'(load), 8'd0);

    // Timeout restarted by an inc
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("tmo2_enter_value", 8'(value), 8'd5);
    for (int k = 0; k < 29; k++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("tmo2_inc_value", 8'(value), 8'd6);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("tmo2_after_inc_tick", 8'(mode), 8'd1);
    for (int k = 0; k < 28; k++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("tmo2_29_still_set", 8'(mode), 8'd1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("tmo2_30_run", 8'(mode), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
